// File: rtl/burst_rr_arbiter.sv
// Round-robin arbiter with burst locking: a grant is held until the holder signals
// last, drops req, or (when ARB_TIMEOUT_EN is defined) runs MAX_BURST cycles.
module burst_rr_arbiter #(
    parameter int N         = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         last,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 grant_valid
);

    localparam int ID_W = $clog2(N);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    if (N < 2 || MAX_BURST < 1) begin : g_bad_param
        $error("burst_rr_arbiter: requires N >= 2 and MAX_BURST >= 1");
    end

    state_e          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [ID_W-1:0] gid_q, gid_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] nxt_ptr;
    logic [ID_W-1:0] sel;
    logic [N-1:0]    cand;
    logic [N-1:0]    search_vec;
    logic [ID_W-1:0] search_start;
    logic            rel;
    logic            to;

    // First set bit of vec, searched cyclically from start.
    function automatic logic [ID_W-1:0] pick(input logic [N-1:0] vec, input logic [ID_W-1:0] start);
        logic [ID_W-1:0] res;
        logic            found;
        int              pos;
        res   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos = int'(start) + k;
            if (pos >= N) pos -= N;
            if (!found && vec[ID_W'(pos)]) begin
                found = 1'b1;
                res   = ID_W'(pos);
            end
        end
        return res;
    endfunction

`ifdef ARB_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign to    = (cnt_q == CNT_LAST);
    // Count beats only while the burst continues; every new grant starts at zero.
    assign cnt_d = (state_q == BUSY && !rel) ? cnt_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign to = 1'b0;
`endif

    assign rel          = !req[gid_q] | last[gid_q] | to;
    assign nxt_ptr      = (gid_q == ID_W'(N - 1)) ? '0 : gid_q + 1'b1;
    // The holder is masked so a release always hands over when anyone else waits.
    assign cand         = req & ~grant_q;
    assign search_vec   = (state_q == IDLE) ? req : cand;
    assign search_start = (state_q == IDLE) ? ptr_q : nxt_ptr;
    assign sel          = pick(search_vec, search_start);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d = state_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = N'(1) << sel;
                    gid_d   = sel;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (rel) begin
                    ptr_d = nxt_ptr;
                    if (|cand) begin
                        grant_d = N'(1) << sel;
                        gid_d   = sel;
                    end else begin
                        grant_d = '0;
                        gid_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = gid_q;
    assign grant_valid = |grant_q;

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Scoreboard bench for burst_rr_arbiter (N=4, MAX_BURST=4); expected grants come
// from a cycle model and from literal sequences of the directed scenarios.
module tb_burst_rr_arbiter;

    localparam int N         = 4;
    localparam int MAX_BURST = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] grant;
        logic [1:0]   id;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] last;
    logic [N-1:0] grant;
    logic [1:0]   grant_id;
    logic         grant_valid;

    exp_t sb[$];
    int   n_vec;
    int   n_err;

    int   m_h;
    int   m_ptr;
    int   m_cnt;

    burst_rr_arbiter #(.N(N), .MAX_BURST(MAX_BURST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .last       (last),
        .grant      (grant),
        .grant_id   (grant_id),
        .grant_valid(grant_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int first_from(input logic [N-1:0] v, input int s);
        for (int k = 0; k < N; k++) begin
            if (v[(s + k) % N]) return (s + k) % N;
        end
        return -1;
    endfunction

    // Reference model: advance one clock edge given the inputs seen at that edge.
    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l);
        logic [N-1:0] c;
        bit           release_now;
        if (m_h < 0) begin
            if (r != '0) begin
                m_h   = first_from(r, m_ptr);
                m_cnt = 0;
            end
        end else begin
            release_now = !r[m_h] || l[m_h] || (TO_EN && m_cnt == MAX_BURST - 1);
            if (!release_now) begin
                m_cnt++;
            end else begin
                m_ptr = (m_h + 1) % N;
                c      = r;
                c[m_h] = 1'b0;
                m_h    = first_from(c, m_ptr);
                m_cnt  = 0;
            end
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input string tag);
        exp_t e;
        req  = r;
        last = l;
        model_step(r, l);
        e.grant = (m_h < 0) ? '0 : N'(1) << m_h;
        e.id    = (m_h < 0) ? 2'd0 : 2'(m_h);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check({tag, "_grant"}, grant, e.grant);
        check({tag, "_id"}, grant_id, e.id);
        check({tag, "_valid"}, grant_valid, |e.grant);
    endtask

    task automatic do_reset(input string tag);
        req   = '0;
        last  = '0;
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_grant"}, grant, 0);
        check({tag, "_rst_id"}, grant_id, 0);
        check({tag, "_rst_valid"}, grant_valid, 0);
        m_h   = -1;
        m_ptr = 0;
        m_cnt = 0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] exp_g;
        logic [N-1:0] r;
        logic [N-1:0] l;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        req   = '0;
        last  = '0;
        m_h   = -1;
        m_ptr = 0;
        m_cnt = 0;
        @(negedge clk);

        // Single requester: three grant cycles, one idle cycle, regrant.
        do_reset("single");
        step(4'b0001, 4'b0000, "single_b1");
        check("single_b1_lit", grant, 4'b0001);
        step(4'b0001, 4'b0000, "single_b2");
        step(4'b0001, 4'b0000, "single_b3");
        step(4'b0001, 4'b0001, "single_rel");
        check("single_idle_lit", grant, 4'b0000);
        step(4'b0001, 4'b0000, "single_regrant");
        check("single_regrant_lit", grant, 4'b0001);
        step(4'b0000, 4'b0000, "single_drop");

        // Full rotation: each holder asserts last on its second cycle.
        do_reset("rot");
        step(4'b1111, 4'b0000, "rot_first");
        check("rot_first_lit", grant, 4'b0001);
        for (int g = 0; g < 5; g++) begin
            step(4'b1111, 4'b0000, "rot_beat2");
            exp_g = N'(1) << (g % N);
            check("rot_beat2_lit", grant, exp_g);
            step(4'b1111, exp_g, "rot_hand");
            exp_g = N'(1) << ((g + 1) % N);
            check("rot_hand_lit", grant, exp_g);
        end

        // Never-ending burst: preempted every MAX_BURST cycles only with the timeout.
        do_reset("to");
        step(4'b0101, 4'b0000, "to_first");
        check("to_first_lit", grant, 4'b0001);
        for (int i = 1; i < 52; i++) begin
            step(4'b0101, 4'b0000, "to_hold");
            exp_g = (TO_EN && ((i / MAX_BURST) % 2 == 1)) ? 4'b0100 : 4'b0001;
            check("to_hold_lit", grant, exp_g);
        end

        // Holder drops req: search resumes after it.
        do_reset("drop");
        step(4'b0010, 4'b0000, "drop_g1");
        check("drop_g1_lit", grant, 4'b0010);
        step(4'b1001, 4'b0000, "drop_hand");
        check("drop_hand_lit", grant, 4'b1000);
        step(4'b1001, 4'b1000, "drop_last");
        check("drop_last_lit", grant, 4'b0001);

        // Asynchronous reset during beat 2, then restart from requester 0.
        do_reset("mid");
        step(4'b0100, 4'b0000, "mid_b1");
        step(4'b0100, 4'b0000, "mid_b2");
        check("mid_b2_lit", grant, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_async_grant", grant, 0);
        check("mid_async_id", grant_id, 0);
        check("mid_async_valid", grant_valid, 0);
        m_h   = -1;
        m_ptr = 0;
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1100, 4'b0000, "mid_restart");
        check("mid_restart_lit", grant, 4'b0100);

        // Random traffic, including last pulses from non-holders.
        do_reset("rnd");
        for (int i = 0; i < 400; i++) begin
            r = 4'($urandom_range(0, 15));
            l = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            step(r, l, "rnd");
            check("rnd_onehot", {31'd0, $onehot0(grant)}, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
